storeblock_seq: RTL and testbench

- Store-side counterpart to the load path: turns a pipeline store request into the byte-lane-aligned write for the word-organised BLOCKRAM DATAMEM.
- Handles SB/SH/SW at any byte offset. Stores that cross a word boundary are split into two sequential word writes.
- Sits between the MEM stage and the DATAMEM write port. Uses a valid/ready handshake so the pipeline stalls during split stores.

---
 rtl/storeblock_seq_if.sv | 25 ++
 rtl/storeblock_seq.sv | 118 +++++++++++
 tb/tb_storeblock_seq.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/storeblock_seq_if.sv
// Store request / DATAMEM write bundle between the MEM stage (master) and storeblock_seq (slave).
interface storeblock_seq_if #(
    parameter int unsigned ADDR_WIDTH = 12
);
    logic                    req_valid;
    logic                    req_ready;
    logic [ADDR_WIDTH+1:0]   req_addr;
    logic [31:0]             req_wdata;
    logic [2:0]              dm_select;
    logic [ADDR_WIDTH-1:0]   dm_addr;
    logic [31:0]             dm_wdata;
    logic [3:0]              dm_we;
    logic                    done;
    logic                    err;

    modport master (
        output req_valid, req_addr, req_wdata, dm_select,
        input  req_ready, dm_addr, dm_wdata, dm_we, done, err
    );

    modport slave (
        input  req_valid, req_addr, req_wdata, dm_select,
        output req_ready, dm_addr, dm_wdata, dm_we, done, err
    );
endinterface

// File: rtl/storeblock_seq.sv
// Store aligner for word-organised DATAMEM: SB/SH/SW at any byte offset, word-crossing stores
// are issued as two sequential beats while req_ready is held low.
module storeblock_seq #(
    parameter int unsigned ADDR_WIDTH = 12
) (
    input logic            clk,
    input logic            rst,
    storeblock_seq_if.slave bus
);
    typedef enum logic [0:0] {StIdle, StBeat2} state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   dm_addr_q;
    logic [31:0]             dm_wdata_q;
    logic [3:0]              dm_we_q;
    logic                    done_q;
    logic                    err_q;
    logic [ADDR_WIDTH-1:0]   hi_addr_q;
    logic [31:0]             hi_wdata_q;
    logic [3:0]              hi_we_q;

    logic [1:0]              off;
    logic [ADDR_WIDTH-1:0]   word_addr;
    logic [2:0]              cnt;
    logic                    illegal;
    logic                    split;
    logic [31:0]             lo_data, hi_data;
    logic [3:0]              lo_we, hi_we;

    assign off       = bus.req_addr[1:0];
    assign word_addr = bus.req_addr[ADDR_WIDTH+1:2];
    assign split     = ({2'b00, off} + {1'b0, cnt}) > 4'd4;

    always_comb begin
        cnt     = 3'd0;
        illegal = 1'b0;
        case (bus.dm_select)
            3'b000:  cnt = 3'd1;
            3'b001:  cnt = 3'd2;
            3'b010:  cnt = 3'd4;
            default: illegal = 1'b1;
        endcase
    end

    // Byte k lands in lane (off+k) mod 4; the carry out of that sum selects the second word.
    always_comb begin
        lo_data = '0;
        hi_data = '0;
        lo_we   = '0;
        hi_we   = '0;
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < cnt) begin
                if (({1'b0, off} + 3'(k)) < 3'd4) begin
                    lo_data = lo_data | ({bus.req_wdata[8*k +: 8], 24'h0} >> {off + 2'(k), 3'b000});
                    lo_we   = lo_we | (4'b1000 >> (off + 2'(k)));
                end else begin
                    hi_data = hi_data | ({bus.req_wdata[8*k +: 8], 24'h0} >> {off + 2'(k), 3'b000});
                    hi_we   = hi_we | (4'b1000 >> (off + 2'(k)));
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            dm_addr_q  <= '0;
            dm_wdata_q <= '0;
            dm_we_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            hi_addr_q  <= '0;
            hi_wdata_q <= '0;
            hi_we_q    <= '0;
        end else begin
            dm_we_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.req_valid) begin
                        if (illegal) begin
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end else begin
                            dm_addr_q  <= word_addr;
                            dm_wdata_q <= lo_data;
                            dm_we_q    <= lo_we;
                            if (split) begin
                                state_q    <= StBeat2;
                                hi_addr_q  <= word_addr + 1'b1;
                                hi_wdata_q <= hi_data;
                                hi_we_q    <= hi_we;
                            end else begin
                                done_q <= 1'b1;
                            end
                        end
                    end
                end
                StBeat2: begin
                    state_q    <= StIdle;
                    dm_addr_q  <= hi_addr_q;
                    dm_wdata_q <= hi_wdata_q;
                    dm_we_q    <= hi_we_q;
                    done_q     <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.req_ready = (state_q == StIdle);
    assign bus.dm_addr   = dm_addr_q;
    assign bus.dm_wdata  = dm_wdata_q;
    assign bus.dm_we     = dm_we_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_storeblock_seq.sv
// Bench for storeblock_seq: byte-address model of expected write beats plus directed literal checks.
module tb_storeblock_seq;
    localparam int unsigned AW = 12;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [3:0]    we;
        logic          done;
        logic          err;
        logic          chk;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    beat_t exp_q[$];
    beat_t cur;
    logic  m_ready = 1'b1;
    logic  mon_on = 1'b0;

    storeblock_seq_if #(.ADDR_WIDTH(AW)) bus ();

    storeblock_seq #(.ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every store byte k goes to byte address addr+k; group bytes by the word they land in.
    task automatic model_accept(input logic [AW+1:0] addr, input logic [31:0] data,
                                input logic [2:0] sel);
        int cnt;
        beat_t b0, b1;
        logic [AW+1:0] a;
        logic [AW-1:0] w0;
        int lane;
        bit spl;
        case (sel)
            3'b000:  cnt = 1;
            3'b001:  cnt = 2;
            3'b010:  cnt = 4;
            default: cnt = 0;
        endcase
        if (cnt == 0) begin
            exp_q.push_back('{addr: '0, data: '0, we: 4'b0, done: 1'b1, err: 1'b1, chk: 1'b0});
            return;
        end
        w0 = addr[AW+1:2];
        b0 = '{addr: w0, data: '0, we: 4'b0, done: 1'b1, err: 1'b0, chk: 1'b1};
        b1 = '{addr: w0 + 1'b1, data: '0, we: 4'b0, done: 1'b1, err: 1'b0, chk: 1'b1};
        spl = 0;
        for (int k = 0; k < cnt; k++) begin
            a = addr + (AW+2)'(k);
            lane = int'(a % 4);
            if (a[AW+1:2] == w0) begin
                b0.data[8*(3-lane) +: 8] = data[8*k +: 8];
                b0.we[3-lane] = 1'b1;
            end else begin
                b1.data[8*(3-lane) +: 8] = data[8*k +: 8];
                b1.we[3-lane] = 1'b1;
                spl = 1;
            end
        end
        if (spl) begin
            b0.done = 1'b0;
            exp_q.push_back(b0);
            exp_q.push_back(b1);
        end else begin
            exp_q.push_back(b0);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            cur = '{addr: '0, data: '0, we: 4'b0, done: 1'b0, err: 1'b0, chk: 1'b1};
            m_ready = 1'b1;
            mon_on = 1'b1;
        end else begin
            if (bus.req_valid && m_ready)
                model_accept(bus.req_addr, bus.req_wdata, bus.dm_select);
            if (exp_q.size() > 0) cur = exp_q.pop_front();
            else cur = '{addr: '0, data: '0, we: 4'b0, done: 1'b0, err: 1'b0, chk: 1'b0};
            m_ready = (exp_q.size() == 0);
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            check_val("model req_ready", {31'b0, bus.req_ready}, {31'b0, m_ready});
            check_val("model dm_we", {28'b0, bus.dm_we}, {28'b0, cur.we});
            check_val("model done", {31'b0, bus.done}, {31'b0, cur.done});
            check_val("model err", {31'b0, bus.err}, {31'b0, cur.err});
            if (cur.chk) begin
                check_val("model dm_addr", 32'(bus.dm_addr), 32'(cur.addr));
                check_val("model dm_wdata", bus.dm_wdata, cur.data);
            end
        end
    end

    task automatic lit_ctl(input string name, input logic [3:0] we, input logic done,
                           input logic err, input logic ready);
        check_val({name, " dm_we"}, {28'b0, bus.dm_we}, {28'b0, we});
        check_val({name, " done"}, {31'b0, bus.done}, {31'b0, done});
        check_val({name, " err"}, {31'b0, bus.err}, {31'b0, err});
        check_val({name, " req_ready"}, {31'b0, bus.req_ready}, {31'b0, ready});
    endtask

    task automatic lit_beat(input string name, input logic [AW-1:0] addr, input logic [31:0] data,
                            input logic [3:0] we, input logic done, input logic ready);
        check_val({name, " dm_addr"}, 32'(bus.dm_addr), 32'(addr));
        check_val({name, " dm_wdata"}, bus.dm_wdata, data);
        lit_ctl(name, we, done, 1'b0, ready);
    endtask

    // Holds the request until the block is ready, returns 2 time units after the accepting edge.
    task automatic send(input logic [AW+1:0] addr, input logic [31:0] data, input logic [2:0] sel);
        int n;
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_wdata = data;
        bus.dm_select = sel;
        n = 0;
        while (!bus.req_ready && n < 10) begin
            @(posedge clk);
            #2;
            n++;
        end
        check_val("accept within budget", 32'(n < 10), 32'd1);
        @(posedge clk);
        #2;
        bus.req_valid = 1'b0;
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.dm_select = 3'b000;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        lit_beat("reset", 12'h000, 32'h0, 4'b0000, 1'b0, 1'b1);

        send(14'h0100, 32'h11223344, 3'b010);
        @(negedge clk);
        lit_beat("sw aligned", 12'h040, 32'h44332211, 4'b1111, 1'b1, 1'b1);

        send(14'h0102, 32'h123456AB, 3'b000);
        @(negedge clk);
        lit_beat("sb off2", 12'h040, 32'h0000AB00, 4'b0010, 1'b1, 1'b1);

        send(14'h0103, 32'h123456AB, 3'b000);
        @(negedge clk);
        lit_beat("sb off3", 12'h040, 32'h000000AB, 4'b0001, 1'b1, 1'b1);

        send(14'h010A, 32'h0000CAFE, 3'b001);
        @(negedge clk);
        lit_beat("sh off2", 12'h042, 32'h0000FECA, 4'b0011, 1'b1, 1'b1);

        send(14'h0103, 32'h0000BEEF, 3'b001);
        @(negedge clk);
        lit_beat("sh split b1", 12'h040, 32'h000000EF, 4'b0001, 1'b0, 1'b0);
        @(negedge clk);
        lit_beat("sh split b2", 12'h041, 32'hBE000000, 4'b1000, 1'b1, 1'b1);

        send(14'h3FFE, 32'hDDCCBBAA, 3'b010);
        @(negedge clk);
        lit_beat("sw wrap b1", 12'hFFF, 32'h0000AABB, 4'b0011, 1'b0, 1'b0);
        @(negedge clk);
        lit_beat("sw wrap b2", 12'h000, 32'hCCDD0000, 4'b1100, 1'b1, 1'b1);

        // Three aligned SWs with req_valid held high.
        @(posedge clk);
        #2;
        bus.req_valid = 1'b1;
        bus.dm_select = 3'b010;
        bus.req_addr  = 14'h0200;
        bus.req_wdata = 32'hA0A1A2A3;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
            if (i < 2) begin
                bus.req_addr  = 14'h0204 + 14'(4 * i);
                bus.req_wdata = 32'hB0B1B2B3 + 32'(i);
            end else begin
                bus.req_valid = 1'b0;
            end
            @(negedge clk);
            check_val("b2b dm_addr", 32'(bus.dm_addr), 32'h080 + 32'(i));
            lit_ctl("b2b", 4'b1111, 1'b1, 1'b0, 1'b1);
        end
        check_val("b2b last dm_wdata", bus.dm_wdata, 32'hB4B2B1B0);

        send(14'h0101, 32'h01020304, 3'b010);
        rst = 1'b1;
        @(negedge clk);
        lit_beat("abort b1", 12'h040, 32'h00040302, 4'b0111, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        lit_beat("abort reset", 12'h000, 32'h0, 4'b0000, 1'b0, 1'b1);
        @(negedge clk);
        lit_ctl("abort idle", 4'b0000, 1'b0, 1'b0, 1'b1);

        send(14'h0100, 32'hFFFFFFFF, 3'b100);
        @(negedge clk);
        lit_ctl("illegal 100", 4'b0000, 1'b1, 1'b1, 1'b1);
        check_val("illegal holds dm_addr", 32'(bus.dm_addr), 32'h0);

        send(14'h0104, 32'h55555555, 3'b011);
        @(negedge clk);
        lit_ctl("illegal 011", 4'b0000, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        lit_ctl("idle after err", 4'b0000, 1'b0, 1'b0, 1'b1);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end
endmodule
